// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between a data port (A)
// and an instruction-fetch port (B); each access is sequenced by a small FSM.
//
// state | meaning
// IDLE  | no access; arbitrate and latch the winning request
// ACC_A | SRAM access on behalf of the data port
// ACC_B | SRAM access on behalf of the fetch port
// DONE  | bus idle for one cycle while the done pulse is high; no grant
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aAddr,
    input  logic [15:0] aWriteData,
    input  logic [1:0]  aMemControl,
    output logic [15:0] aReadData,
    output logic        aDone,
    output logic        aStall,
    input  logic [15:0] bAddr,
    input  logic        bReq,
    output logic [15:0] bReadData,
    output logic        bDone,
    output logic        bStall,
    output logic [15:0] ramAddr,
    output logic [15:0] ramDataOut,
    input  logic [15:0] ramDataIn,
    output logic        ramDataOE,
    output logic        ramCE_n,
    output logic        ramOE_n,
    output logic        ramWE_n
);

    typedef enum logic [1:0] {IDLE, ACC_A, ACC_B, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        last_grant_a_q, last_grant_a_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic        a_req;
    logic        in_acc;

    // Command 11 is reserved and behaves exactly like idle.
    assign a_req  = (aMemControl == 2'b01) || (aMemControl == 2'b10);
    assign in_acc = (state_q == ACC_A) || (state_q == ACC_B);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            addr_q         <= 16'd0;
            wdata_q        <= 16'd0;
            write_q        <= 1'b0;
            last_grant_a_q <= 1'b0;
            a_rdata_q      <= 16'd0;
            b_rdata_q      <= 16'd0;
            a_done_q       <= 1'b0;
            b_done_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            write_q        <= write_d;
            last_grant_a_q <= last_grant_a_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
            a_done_q       <= a_done_d;
            b_done_q       <= b_done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        write_d        = write_q;
        last_grant_a_d = last_grant_a_q;
        a_rdata_d      = a_rdata_q;
        b_rdata_d      = b_rdata_q;
        a_done_d       = 1'b0;
        b_done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                // On contention the port that did not win last time goes first.
                if (a_req && (!bReq || !last_grant_a_q)) begin
                    addr_d         = aAddr;
                    wdata_d        = aWriteData;
                    write_d        = (aMemControl == 2'b10);
                    cnt_d          = 4'(WAIT_CYCLES);
                    last_grant_a_d = 1'b1;
                    state_d        = ACC_A;
                end else if (bReq) begin
                    addr_d         = bAddr;
                    write_d        = 1'b0;
                    cnt_d          = 4'(WAIT_CYCLES);
                    last_grant_a_d = 1'b0;
                    state_d        = ACC_B;
                end
            end
            ACC_A, ACC_B: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (state_q == ACC_A) begin
                        a_done_d = 1'b1;
                        if (!write_q) a_rdata_d = ramDataIn;
                    end else begin
                        b_done_d  = 1'b1;
                        b_rdata_d = ramDataIn;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // WE is released in the final access cycle so address and data see hold time.
    assign ramAddr    = addr_q;
    assign ramDataOut = wdata_q;
    assign ramDataOE  = in_acc && write_q;
    assign ramCE_n    = !in_acc;
    assign ramOE_n    = !(in_acc && !write_q);
    assign ramWE_n    = !(in_acc && write_q && (cnt_q != 4'd0));

    assign aReadData = a_rdata_q;
    assign bReadData = b_rdata_q;
    assign aDone     = a_done_q;
    assign bDone     = b_done_q;
    assign aStall    = a_req && !a_done_q;
    assign bStall    = bReq && !b_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on WAIT_CYCLES=1 and 3 instances plus a
// randomized run checked against a transaction-level SRAM/scoreboard model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] a_addr, a_wdata, b_addr;
    logic [1:0]  a_ctl;
    logic        b_req;
    logic        ovr_en;
    logic [15:0] ovr_val;
    logic        mem_init;

    logic [15:0] a_rdata1, b_rdata1, ram_addr1, ram_dout1, rdin1;
    logic        a_done1, a_stall1, b_done1, b_stall1, ram_oe1, ram_ce_n1, ram_oe_n1, ram_we_n1;
    logic [15:0] a_rdata3, b_rdata3, ram_addr3, ram_dout3, rdin3;
    logic        a_done3, a_stall3, b_done3, b_stall3, ram_oe3, ram_ce_n3, ram_oe_n3, ram_we_n3;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];

    int n_vec;
    int n_err;

    mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .aAddr(a_addr), .aWriteData(a_wdata), .aMemControl(a_ctl),
        .aReadData(a_rdata1), .aDone(a_done1), .aStall(a_stall1),
        .bAddr(b_addr), .bReq(b_req),
        .bReadData(b_rdata1), .bDone(b_done1), .bStall(b_stall1),
        .ramAddr(ram_addr1), .ramDataOut(ram_dout1), .ramDataIn(rdin1),
        .ramDataOE(ram_oe1), .ramCE_n(ram_ce_n1), .ramOE_n(ram_oe_n1), .ramWE_n(ram_we_n1)
    );

    mem_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .aAddr(a_addr), .aWriteData(a_wdata), .aMemControl(a_ctl),
        .aReadData(a_rdata3), .aDone(a_done3), .aStall(a_stall3),
        .bAddr(b_addr), .bReq(b_req),
        .bReadData(b_rdata3), .bDone(b_done3), .bStall(b_stall3),
        .ramAddr(ram_addr3), .ramDataOut(ram_dout3), .ramDataIn(rdin3),
        .ramDataOE(ram_oe3), .ramCE_n(ram_ce_n3), .ramOE_n(ram_oe_n3), .ramWE_n(ram_we_n3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_pat(int i);
        return 16'(i * 257) ^ 16'h5A3C;
    endfunction

    // Asynchronous SRAM: combinational read, write latched on the rising edge of WE.
    assign rdin1 = ovr_en ? ovr_val : mem[ram_addr1[7:0]];
    assign rdin3 = ovr_en ? ovr_val : mem[ram_addr3[7:0]];

    always @(posedge ram_we_n1 or posedge mem_init) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = mem_pat(i);
        end else if (ram_ce_n1 === 1'b0 && ram_oe1 === 1'b1) begin
            mem[ram_addr1[7:0]] = ram_dout1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_vec++;
        if ({a_rdata1, b_rdata1, a_done1, b_done1, ram_addr1, ram_dout1} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_data1: got %h want 0", {a_rdata1, b_rdata1, a_done1, b_done1, ram_addr1, ram_dout1});
        end
        n_vec++;
        if ({ram_oe1, ram_ce_n1, ram_oe_n1, ram_we_n1, a_stall1, b_stall1} !== 6'b011100) begin
            n_err++;
            $display("FAIL reset_strobes1: got %b want 011100", {ram_oe1, ram_ce_n1, ram_oe_n1, ram_we_n1, a_stall1, b_stall1});
        end
        n_vec++;
        if ({a_rdata3, b_rdata3, a_done3, b_done3, ram_addr3, ram_dout3, ram_oe3, ram_ce_n3, ram_oe_n3,
             ram_we_n3, a_stall3, b_stall3} !== {66'd0, 6'b011100}) begin
            n_err++;
            $display("FAIL reset_all3: got %h want %h", {a_rdata3, b_rdata3, a_done3, b_done3, ram_addr3, ram_dout3,
                     ram_oe3, ram_ce_n3, ram_oe_n3, ram_we_n3, a_stall3, b_stall3}, {66'd0, 6'b011100});
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        ovr_en  = 1'b1;
        ovr_val = 16'h4A01;
        b_addr  = 16'h0010;
        b_req   = 1'b1;
        #1;
        n_vec++;
        if (b_stall1 !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_stall_pre: got %b want 1", b_stall1);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({ram_ce_n1, ram_oe_n1, ram_we_n1, ram_oe1, ram_addr1, b_done1, b_stall1} !== {4'b0010, 16'h0010, 2'b01}) begin
                n_err++;
                $display("FAIL fetch_acc%0d: got %h want %h", i,
                         {ram_ce_n1, ram_oe_n1, ram_we_n1, ram_oe1, ram_addr1, b_done1, b_stall1}, {4'b0010, 16'h0010, 2'b01});
            end
            tick();
        end
        n_vec++;
        if ({b_done1, b_stall1, ram_ce_n1, b_rdata1} !== {3'b101, 16'h4A01}) begin
            n_err++;
            $display("FAIL fetch_done: got %h want %h", {b_done1, b_stall1, ram_ce_n1, b_rdata1}, {3'b101, 16'h4A01});
        end
        b_req = 1'b0;
        tick();
        n_vec++;
        if ({b_done1, b_rdata1} !== {1'b0, 16'h4A01}) begin
            n_err++;
            $display("FAIL fetch_after: got %h want %h", {b_done1, b_rdata1}, {1'b0, 16'h4A01});
        end
        ovr_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_write();
        a_ctl   = 2'b10;
        a_addr  = 16'hBF00;
        a_wdata = 16'h1234;
        tick();
        n_vec++;
        if ({ram_ce_n1, ram_oe_n1, ram_we_n1, ram_oe1, ram_dout1, ram_addr1} !== {4'b0101, 16'h1234, 16'hBF00}) begin
            n_err++;
            $display("FAIL write_acc0: got %h want %h", {ram_ce_n1, ram_oe_n1, ram_we_n1, ram_oe1, ram_dout1, ram_addr1},
                     {4'b0101, 16'h1234, 16'hBF00});
        end
        tick();
        n_vec++;
        if ({ram_ce_n1, ram_oe_n1, ram_we_n1, ram_oe1, ram_dout1, ram_addr1, a_done1} !== {4'b0111, 16'h1234, 16'hBF00, 1'b0}) begin
            n_err++;
            $display("FAIL write_acc1_hold: got %h want %h", {ram_ce_n1, ram_oe_n1, ram_we_n1, ram_oe1, ram_dout1, ram_addr1, a_done1},
                     {4'b0111, 16'h1234, 16'hBF00, 1'b0});
        end
        tick();
        n_vec++;
        if ({a_done1, a_stall1, ram_oe1, ram_we_n1, ram_ce_n1, a_rdata1} !== {5'b10011, 16'h0000}) begin
            n_err++;
            $display("FAIL write_done: got %h want %h", {a_done1, a_stall1, ram_oe1, ram_we_n1, ram_ce_n1, a_rdata1}, {5'b10011, 16'h0000});
        end
        n_vec++;
        if (mem[8'h00] !== 16'h1234) begin
            n_err++;
            $display("FAIL write_sram_content: got %h want 1234", mem[8'h00]);
        end
        a_ctl = 2'b00;
        tick();
        n_vec++;
        if (a_done1 !== 1'b0) begin
            n_err++;
            $display("FAIL write_done_pulse: got %b want 0", a_done1);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_alternate();
        int na, nb;
        na = 0;
        nb = 0;
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        a_ctl  = 2'b01;
        a_addr = 16'h0020;
        b_req  = 1'b1;
        b_addr = 16'h0030;
        // Both held: A done 2 cycles after its grant, then B gets the bus 4 cycles later.
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if ({a_done1, b_done1} !== {1'((i % 8) == 2), 1'((i % 8) == 6)}) begin
                n_err++;
                $display("FAIL alt_cycle%0d: got %b want %b", i, {a_done1, b_done1}, {1'((i % 8) == 2), 1'((i % 8) == 6)});
            end
            na += int'(a_done1);
            nb += int'(b_done1);
        end
        n_vec++;
        if (na != 5 || nb != 5) begin
            n_err++;
            $display("FAIL alt_counts: got a=%0d b=%0d want a=5 b=5", na, nb);
        end
        n_vec++;
        if ({a_rdata1, b_rdata1} !== {mem_pat(32'h20), mem_pat(32'h30)}) begin
            n_err++;
            $display("FAIL alt_rdata: got %h want %h", {a_rdata1, b_rdata1}, {mem_pat(32'h20), mem_pat(32'h30)});
        end
        a_ctl = 2'b00;
        b_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reserved();
        a_ctl = 2'b11;
        b_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if ({ram_ce_n1, ram_oe_n1, ram_we_n1, a_stall1} !== 4'b1110) begin
                n_err++;
                $display("FAIL reserved_cycle%0d: got %b want 1110", i, {ram_ce_n1, ram_oe_n1, ram_we_n1, a_stall1});
            end
        end
        a_ctl = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        a_ctl   = 2'b10;
        a_addr  = 16'h0040;
        a_wdata = 16'hBEEF;
        tick();
        n_vec++;
        if ({ram_we_n1, ram_ce_n1, ram_oe1} !== 3'b001) begin
            n_err++;
            $display("FAIL rstmid_pre: got %b want 001", {ram_we_n1, ram_ce_n1, ram_oe1});
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({ram_we_n1, ram_ce_n1, ram_oe1} !== 3'b110) begin
            n_err++;
            $display("FAIL rstmid_async: got %b want 110", {ram_we_n1, ram_ce_n1, ram_oe1});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({a_done1, ram_ce_n1} !== 2'b01) begin
                n_err++;
                $display("FAIL rstmid_held%0d: got %b want 01", i, {a_done1, ram_ce_n1});
            end
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if ({ram_we_n1, ram_ce_n1, ram_addr1} !== {2'b00, 16'h0040}) begin
            n_err++;
            $display("FAIL rstmid_regrant: got %h want %h", {ram_we_n1, ram_ce_n1, ram_addr1}, {2'b00, 16'h0040});
        end
        tick();
        tick();
        n_vec++;
        if (a_done1 !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_done: got %b want 1", a_done1);
        end
        a_ctl = 2'b00;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_wait3();
        ovr_en  = 1'b1;
        ovr_val = 16'hCAFE;
        a_ctl   = 2'b01;
        a_addr  = 16'h2000;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) a_addr = 16'h2055;
            n_vec++;
            if ({ram_ce_n3, ram_oe_n3, ram_we_n3, ram_addr3, a_done3} !== {3'b001, 16'h2000, 1'b0}) begin
                n_err++;
                $display("FAIL wait3_acc%0d: got %h want %h", i, {ram_ce_n3, ram_oe_n3, ram_we_n3, ram_addr3, a_done3},
                         {3'b001, 16'h2000, 1'b0});
            end
            tick();
        end
        n_vec++;
        if ({a_done3, ram_ce_n3, a_rdata3} !== {2'b11, 16'hCAFE}) begin
            n_err++;
            $display("FAIL wait3_done: got %h want %h", {a_done3, ram_ce_n3, a_rdata3}, {2'b11, 16'hCAFE});
        end
        a_ctl  = 2'b00;
        ovr_en = 1'b0;
        tick();
        n_vec++;
        if ({a_done3, a_rdata3} !== {1'b0, 16'hCAFE}) begin
            n_err++;
            $display("FAIL wait3_after: got %h want %h", {a_done3, a_rdata3}, {1'b0, 16'hCAFE});
        end
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_random();
        logic        a_pend, b_pend, a_wr;
        logic [15:0] a_ad, b_ad, a_dat, a_last, b_last;
        int          a_age, b_age;
        a_pend = 1'b0; b_pend = 1'b0; a_wr = 1'b0;
        a_ad = 16'd0; b_ad = 16'd0; a_dat = 16'd0;
        a_last = 16'd0; b_last = 16'd0;
        a_age = 0; b_age = 0;
        rst = 1'b0;
        mem_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_pat(i);
        tick();
        mem_init = 1'b0;
        rst = 1'b1;
        for (int cyc = 0; cyc < 700; cyc++) begin
            tick();
            n_vec++;
            if (!(ram_we_n1 | ram_oe_n1)) begin
                n_err++;
                $display("FAIL rnd_we_oe_overlap cyc%0d: got we_n=%b oe_n=%b want not both 0", cyc, ram_we_n1, ram_oe_n1);
            end
            n_vec++;
            if (a_done1 === 1'b1 && b_done1 === 1'b1) begin
                n_err++;
                $display("FAIL rnd_both_done cyc%0d: got 11 want at most one", cyc);
            end
            if (a_done1 === 1'b1) begin
                n_vec++;
                if (!a_pend) begin
                    n_err++;
                    $display("FAIL rnd_a_spurious cyc%0d: got done=1 want 0", cyc);
                end else if (a_wr) begin
                    ref_mem[a_ad[7:0]] = a_dat;
                end else begin
                    a_last = ref_mem[a_ad[7:0]];
                end
                a_pend = 1'b0;
                a_ctl  = 2'b00;
            end else if (a_pend) begin
                a_age++;
                n_vec++;
                if (a_age > 10) begin
                    n_err++;
                    $display("FAIL rnd_a_timeout cyc%0d: got wait=%0d want <=10", cyc, a_age);
                    a_pend = 1'b0;
                    a_ctl  = 2'b00;
                end
            end
            if (b_done1 === 1'b1) begin
                n_vec++;
                if (!b_pend) begin
                    n_err++;
                    $display("FAIL rnd_b_spurious cyc%0d: got done=1 want 0", cyc);
                end else begin
                    b_last = ref_mem[b_ad[7:0]];
                end
                b_pend = 1'b0;
                b_req  = 1'b0;
            end else if (b_pend) begin
                b_age++;
                n_vec++;
                if (b_age > 10) begin
                    n_err++;
                    $display("FAIL rnd_b_timeout cyc%0d: got wait=%0d want <=10", cyc, b_age);
                    b_pend = 1'b0;
                    b_req  = 1'b0;
                end
            end
            n_vec++;
            if ({a_rdata1, b_rdata1} !== {a_last, b_last}) begin
                n_err++;
                $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, {a_rdata1, b_rdata1}, {a_last, b_last});
            end
            if (!a_pend && cyc < 680 && $urandom_range(0, 2) == 0) begin
                a_pend  = 1'b1;
                a_age   = 0;
                a_wr    = 1'($urandom_range(0, 1));
                a_ad    = {8'($urandom), 4'h0, 4'($urandom)};
                a_dat   = 16'($urandom);
                a_ctl   = a_wr ? 2'b10 : 2'b01;
                a_addr  = a_ad;
                a_wdata = a_dat;
            end else if (!a_pend) begin
                a_ctl  = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
                a_addr = 16'($urandom);
            end
            if (!b_pend && cyc < 680 && $urandom_range(0, 2) == 0) begin
                b_pend = 1'b1;
                b_age  = 0;
                b_ad   = {8'($urandom), 4'h0, 4'($urandom)};
                b_req  = 1'b1;
                b_addr = b_ad;
            end
        end
        n_vec++;
        if (a_pend || b_pend) begin
            n_err++;
            $display("FAIL rnd_drain: got pending a=%b b=%b want 0 0", a_pend, b_pend);
        end
        a_ctl = 2'b00;
        b_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        a_addr   = 16'd0;
        a_wdata  = 16'd0;
        a_ctl    = 2'b00;
        b_addr   = 16'd0;
        b_req    = 1'b0;
        ovr_en   = 1'b0;
        ovr_val  = 16'd0;
        mem_init = 1'b1;
        #1;
        mem_init = 1'b0;
        test_reset();
        test_fetch();
        test_write();
        test_alternate();
        test_reserved();
        test_reset_mid();
        test_wait3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
